// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-port synchronous SRAM between two requesters.
//            Port A is typically video/sprite scan and port B the CPU.
//            Arbitration is done per cycle. All SRAM controls are registered.
//            Read data is returned with a per-port valid strobe that lines
//            up with the SRAM Q output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> port A always wins a simultaneous request
//                                   (no round-robin pointer exists)
//                      undefined -> round-robin between A and B (default)
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1           system clock, shared with the SRAM
//   reset_n    in   1           asynchronous reset, active low
//   a_req      in   1           port A request, held stable until a_ack
//   a_we       in   1           port A 1 = write, 0 = read
//   a_addr     in   ADDR_WIDTH  port A address
//   a_wdata    in   DATA_WIDTH  port A write data
//   a_ack      out  1           port A request accepted at the coming edge
//   a_rvalid   out  1           a_rdata holds a port A read result
//   a_rdata    out  DATA_WIDTH  read data (wired to sram_q)
//   b_*                         identical set for port B
//   sram_addr  out  ADDR_WIDTH  registered SRAM address
//   sram_data  out  DATA_WIDTH  registered SRAM write data
//   sram_cen   out  1           registered chip enable, active low
//   sram_oen   out  1           registered output enable, active low
//   sram_wen   out  1           registered write enable, active low
//   sram_q     in   DATA_WIDTH  SRAM read data
// ============================================================================
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port A
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  // port B
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  // SRAM pins
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_cen,
  output logic                  sram_oen,
  output logic                  sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // Port identifiers carried in the read-return pipeline.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic grant_a;
  logic grant_b;

`ifdef ARB_FIXED_PRIO_EN
  // A strictly outranks B; B only gets the SRAM when A is not asking.
  always_comb begin
    grant_a = a_req;
    grant_b = b_req & ~a_req;
  end
`else
  // prefer_b_q set means A was granted last, so B wins the next tie.
  // It only moves on an accepted transfer, so a requester that withdraws
  // before being acked leaves fairness untouched.
  logic prefer_b_q;
  logic prefer_b_d;

  always_comb begin
    grant_a    = a_req & (~b_req | ~prefer_b_q);
    grant_b    = b_req & ~grant_a;
    prefer_b_d = prefer_b_q;
    if (grant_a) begin
      prefer_b_d = 1'b1;
    end else if (grant_b) begin
      prefer_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end
`endif

  assign a_ack = grant_a;
  assign b_ack = grant_b;

  // --------------------------------------------------------------------------
  // Selected transfer
  // --------------------------------------------------------------------------
  logic                  xfer;
  logic                  xfer_we;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  xfer_port;

  always_comb begin
    xfer       = grant_a | grant_b;
    xfer_port  = grant_b ? PORT_B : PORT_A;
    xfer_we    = grant_b ? b_we    : a_we;
    xfer_addr  = grant_b ? b_addr  : a_addr;
    xfer_wdata = grant_b ? b_wdata : a_wdata;
  end

  // --------------------------------------------------------------------------
  // SRAM control registers
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_data_q, sram_data_d;
  logic                  sram_cen_q,  sram_cen_d;
  logic                  sram_oen_q,  sram_oen_d;
  logic                  sram_wen_q,  sram_wen_d;

  always_comb begin
    // Address and data only change on a transfer so the pins stay quiet
    // during idle cycles.
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    if (xfer) begin
      sram_addr_d = xfer_addr;
      sram_data_d = xfer_wdata;
    end
    sram_cen_d = ~xfer;
    sram_oen_d = ~(xfer & ~xfer_we);
    sram_wen_d = ~(xfer &  xfer_we);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr_q <= '0;
      sram_data_q <= '0;
      sram_cen_q  <= 1'b1;
      sram_oen_q  <= 1'b1;
      sram_wen_q  <= 1'b1;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      sram_cen_q  <= sram_cen_d;
      sram_oen_q  <= sram_oen_d;
      sram_wen_q  <= sram_wen_d;
    end
  end

  assign sram_addr = sram_addr_q;
  assign sram_data = sram_data_q;
  assign sram_cen  = sram_cen_q;
  assign sram_oen  = sram_oen_q;
  assign sram_wen  = sram_wen_q;

  // --------------------------------------------------------------------------
  // Read-return pipeline
  // Stage 1 covers the cycle the SRAM controls are on the pins; stage 2
  // covers the cycle after the SRAM sampled them, when Q is valid. Writes
  // enter as invalid so they never raise rvalid.
  // --------------------------------------------------------------------------
  logic rd_vld_s1_q,  rd_vld_s1_d;
  logic rd_port_s1_q, rd_port_s1_d;
  logic rd_vld_s2_q,  rd_vld_s2_d;
  logic rd_port_s2_q, rd_port_s2_d;

  always_comb begin
    rd_vld_s1_d  = xfer & ~xfer_we;
    rd_port_s1_d = xfer_port;
    rd_vld_s2_d  = rd_vld_s1_q;
    rd_port_s2_d = rd_port_s1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_s1_q  <= 1'b0;
      rd_port_s1_q <= PORT_A;
      rd_vld_s2_q  <= 1'b0;
      rd_port_s2_q <= PORT_A;
    end else begin
      rd_vld_s1_q  <= rd_vld_s1_d;
      rd_port_s1_q <= rd_port_s1_d;
      rd_vld_s2_q  <= rd_vld_s2_d;
      rd_port_s2_q <= rd_port_s2_d;
    end
  end

  assign a_rvalid = rd_vld_s2_q & (rd_port_s2_q == PORT_A);
  assign b_rvalid = rd_vld_s2_q & (rd_port_s2_q == PORT_B);

  // Both ports see Q directly; rvalid is the only qualifier.
  assign a_rdata = sram_q;
  assign b_rdata = sram_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter with a behavioural
//            synchronous SRAM and a read-return scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack, a_rvalid, b_ack, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          sram_cen, sram_oen, sram_wen;
  logic [DW-1:0] sram_q = '0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .sram_q(sram_q)
  );

  // Behavioural single-port synchronous SRAM, registered Q.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen)      mem[sram_addr] <= sram_data;
      else if (!sram_oen) sram_q <= mem[sram_addr];
    end
  end

  // Scoreboard entry: which port should see rvalid, the data, and the
  // cycle count at which it is due.
  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } sb_t;

  sb_t  sb[$];
  logic ack_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: acks seen at the negedge are accepted at the next posedge.
  always @(negedge clk) begin : mon
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    sb_t           e;
    if (reset_n) begin
      if (a_ack || b_ack) begin
        check_eq("one_ack", {31'd0, a_ack & b_ack}, 0);
        we = a_ack ? a_we    : b_we;
        ad = a_ack ? a_addr  : b_addr;
        wd = a_ack ? a_wdata : b_wdata;
        ack_log.push_back(b_ack);
        if (we) ref_mem[ad] = wd;
        else    sb.push_back('{port: b_ack, data: ref_mem[ad], due: cyc + 2});
      end
      if (a_rvalid || b_rvalid) begin
        if (sb.size() == 0) begin
          check_eq("rvalid_unexpected", {30'd0, a_rvalid, b_rvalid}, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rv_port",  {30'd0, a_rvalid, b_rvalid}, e.port ? 32'd1 : 32'd2);
          check_eq("rv_data",  {24'd0, (b_rvalid ? b_rdata : a_rdata)}, {24'd0, e.data});
          check_eq("rv_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        check_eq("rvalid_missing", {30'd0, a_rvalid, b_rvalid}, sb[0].port ? 32'd1 : 32'd2);
        void'(sb.pop_front());
      end
    end
  end

  task automatic check_idle_pins(input string tag);
    check_eq({tag, "_cen"}, {31'd0, sram_cen}, 1);
    check_eq({tag, "_oen"}, {31'd0, sram_oen}, 1);
    check_eq({tag, "_wen"}, {31'd0, sram_wen}, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i * 7 + 1);
      ref_mem[i] = DW'(i * 7 + 1);
    end
    mem[5]     = 8'h3C;
    ref_mem[5] = 8'h3C;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check_idle_pins("rst");
    check_eq("rst_addr", {22'd0, sram_addr}, 0);
    check_eq("rst_data", {24'd0, sram_data}, 0);
    check_eq("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    @(negedge clk) reset_n = 1'b1;

    // ---- A reads 0x005: latency, pin timing, idle cycle ----
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
    @(negedge clk);
    check_eq("t1_ack", {31'd0, a_ack}, 1);
    @(posedge clk); #1;
    a_req = 1'b0;
    check_eq("t1_cen", {31'd0, sram_cen}, 0);
    check_eq("t1_oen", {31'd0, sram_oen}, 0);
    check_eq("t1_wen", {31'd0, sram_wen}, 1);
    check_eq("t1_addr", {22'd0, sram_addr}, 32'h005);
    @(negedge clk);
    check_eq("t1_early_rvalid", {31'd0, a_rvalid}, 0);
    @(posedge clk); #1;
    check_idle_pins("t4_idle");
    check_eq("t4_addr_hold", {22'd0, sram_addr}, 32'h005);
    @(negedge clk);
    check_eq("t1_rvalid", {31'd0, a_rvalid}, 1);
    check_eq("t1_rdata", {24'd0, a_rdata}, 32'h3C);
    @(negedge clk);
    check_eq("t1_rvalid_one", {31'd0, a_rvalid}, 0);

    // ---- B writes 0xA5 to 0x010, then reads it back-to-back ----
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h010; b_wdata = 8'hA5;
    @(negedge clk);
    check_eq("t2_wr_ack", {31'd0, b_ack}, 1);
    @(posedge clk); #1;
    check_eq("t2_wen", {31'd0, sram_wen}, 0);
    check_eq("t2_oen", {31'd0, sram_oen}, 1);
    check_eq("t2_wdata", {24'd0, sram_data}, 32'hA5);
    b_we = 1'b0;
    @(negedge clk);
    check_eq("t2_rd_ack", {31'd0, b_ack}, 1);
    @(posedge clk); #1;
    b_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t2_ref", {24'd0, ref_mem[10'h010]}, 32'hA5);

    // ---- A and B both request reads continuously ----
    @(posedge clk); #1;
    ack_log.delete();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h020;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h021;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    check_eq("t3_nacks", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      check_eq("t3_order", {31'd0, ack_log[i]}, 0);
`else
      check_eq("t3_order", {31'd0, ack_log[i]}, i % 2);
`endif
    end
    repeat (4) @(negedge clk);

    // ---- reset one cycle after a read ack ----
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h007;
    @(negedge clk);
    check_eq("t5_ack", {31'd0, a_ack}, 1);
    @(posedge clk); #1;
    a_req = 1'b0;
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check_idle_pins("t5_async");
    check_eq("t5_addr", {22'd0, sram_addr}, 0);
    check_eq("t5_data", {24'd0, sram_data}, 0);
    check_eq("t5_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    end

    // ---- pointer favours A after reset ----
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h030;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h031;
    @(negedge clk);
    check_eq("t6_a_first", {30'd0, a_ack, b_ack}, 2);
    @(posedge clk); #1;
    a_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (b_ack) got = 1'b1;
    end
    check_eq("t6_b_ack", {31'd0, got}, 1);
    @(posedge clk); #1;
    b_req = 1'b0;

    repeat (5) @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
